// File: rtl/step_pkg.sv
// Shared definitions for the push-button step-pulse front end: FSM state
// encoding and default widths.
package step_pkg;

    // Default width of the debounce and repeat counters.
    localparam int CNT_W_DEF = 28;

    // Width of the press counter (wraps modulo 2^PCNT_W).
    localparam int PCNT_W = 8;

    // Debounce FSM state encoding.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset.
// Brings an asynchronous level (buttons, switches) into the clk_i domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // Two-stage capture; only the second stage is safe to use downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Push-button front end: synchronizes and debounces a bouncing button,
// producing a clean level, a one-cycle step pulse per accepted press and a
// wrapping press counter.
// Optional build macro STEP_PULSE_AUTO_REPEAT_EN adds hold-to-repeat pulses
// (first after REPEAT_DELAY cycles of hold, then every REPEAT_PERIOD cycles).
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int               CNT_W           = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(200000)
`ifdef STEP_PULSE_AUTO_REPEAT_EN
    ,
    parameter logic [CNT_W-1:0] REPEAT_DELAY    = CNT_W'(50000000),
    parameter logic [CNT_W-1:0] REPEAT_PERIOD   = CNT_W'(10000000)
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_raw,
    output logic              btn_level,
    output logic              step_pulse,
    output logic [PCNT_W-1:0] press_count
);

    // Last value of the debounce counter before a decision is taken.
    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - CNT_W'(1);

    logic              sync2;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              pulse_q, pulse_d;
    logic [PCNT_W-1:0] count_q, count_d;

`ifdef STEP_PULSE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = REPEAT_DELAY - CNT_W'(1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = REPEAT_PERIOD - CNT_W'(1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    // Set once the first repeat has fired; later repeats use the period.
    logic             rpt_per_q, rpt_per_d;
`endif

    sync_2ff #(
        .W(1)
    ) u_sync (
        .clk_i(clock),
        .rst_i(reset),
        .d_i  (btn_raw),
        .q_o  (sync2)
    );

    // Next-state logic for the debounce FSM, its counters and registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
        rpt_per_d = rpt_per_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sync2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
                    rpt_cnt_d = '0;
                    rpt_per_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
                    rpt_cnt_d = '0;
                    rpt_per_d = 1'b0;
`endif
                end else begin
`ifdef STEP_PULSE_AUTO_REPEAT_EN
                    if (rpt_cnt_q == (rpt_per_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                        pulse_d   = 1'b1;
                        rpt_cnt_d = '0;
                        rpt_per_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                    end
`else
                    state_d = PRESSED;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    // Release bounce: back to held, no new pulse.
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
                    rpt_cnt_d = '0;
                    rpt_per_d = 1'b0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        count_d = count_q + {{(PCNT_W-1){1'b0}}, pulse_d};
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
            rpt_cnt_q <= '0;
            rpt_per_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
`ifdef STEP_PULSE_AUTO_REPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
            rpt_per_q <= rpt_per_d;
`endif
        end
    end

    assign btn_level   = level_q;
    assign step_pulse  = pulse_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with a short debounce window.
// Expected pulses (edge number and press count) are queued when the button is
// driven and matched by a monitor whenever step_pulse is seen high.
module tb_step_pulse_gen;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic       btn_raw;
    logic       btn_level;
    logic       step_pulse;
    logic [7:0] press_count;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  exp_cnt;
    int unsigned cyc;
    int unsigned pulses_seen;
    int unsigned n_checks;
    int unsigned n_pass;

    step_pulse_gen #(
        .CNT_W          (28),
        .DEBOUNCE_CYCLES(28'd4)
`ifdef STEP_PULSE_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY   (28'd20),
        .REPEAT_PERIOD  (28'd5)
`endif
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .step_pulse (step_pulse),
        .press_count(press_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter: after posedge number E, cyc == E.
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_pulse(input int unsigned at);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.cyc = at;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    // One clean press and release, each held well past the debounce window.
    task automatic press_once();
        btn_raw = 1'b1;
        expect_pulse(cyc + 1 + D + 2);
        step(D + 4);
        btn_raw = 1'b0;
        step(D + 4);
    endtask

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && step_pulse) begin
            exp_t e;
            pulses_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse_edge", cyc, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_edge", cyc, e.cyc);
                chk("pulse_count", 32'(press_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        int unsigned p0;
        int unsigned k;
        int unsigned a;
        n_checks    = 0;
        n_pass      = 0;
        pulses_seen = 0;
        exp_cnt     = 8'd0;
        reset       = 1'b1;
        btn_raw     = 1'b0;

        step(3);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_count", 32'(press_count), 32'd0);
        reset = 1'b0;

        // Clean press: btn_raw high from edge 10, pulse after edge 16.
        while (cyc < 9) step(1);
        btn_raw = 1'b1;
        expect_pulse(32'd16);
        step(6);
        chk("clean_level_early", 32'(btn_level), 32'd0);
        chk("clean_pulse_early", 32'(step_pulse), 32'd0);
        step(1);
        chk("clean_level", 32'(btn_level), 32'd1);
        step(1);
        chk("clean_pulse_width", 32'(step_pulse), 32'd0);
        chk("clean_count", 32'(press_count), 32'd1);
        step(3);
        btn_raw = 1'b0;
        step(D + 2);
        chk("release_level_hold", 32'(btn_level), 32'd1);
        step(1);
        chk("release_level_drop", 32'(btn_level), 32'd0);
        step(3);
        chk("clean_pending", 32'(exp_q.size()), 32'd0);

        // Press bounce: 3 high / 1 low five times, then steady high.
        p0 = pulses_seen;
        repeat (5) begin
            btn_raw = 1'b1;
            step(3);
            btn_raw = 1'b0;
            step(1);
        end
        btn_raw = 1'b1;
        expect_pulse(cyc + 1 + D + 2);
        step(D + 4);
        chk("bounce_level", 32'(btn_level), 32'd1);
        chk("bounce_pulses", pulses_seen - p0, 32'd1);
        chk("bounce_count", 32'(press_count), 32'd2);

        // Release bounce: short low glitch while held must not drop level or pulse.
        p0 = pulses_seen;
        btn_raw = 1'b0;
        step(2);
        btn_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("rel_bounce_level", 32'(btn_level), 32'd1);
        end
        btn_raw = 1'b0;
        step(D + 2);
        chk("rel_steady_hold", 32'(btn_level), 32'd1);
        step(1);
        chk("rel_steady_drop", 32'(btn_level), 32'd0);
        chk("rel_bounce_pulses", pulses_seen - p0, 32'd0);
        step(3);

        // Reset while in PRESS_WAIT with the button held.
        btn_raw = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        chk("midrst_level", 32'(btn_level), 32'd0);
        chk("midrst_pulse", 32'(step_pulse), 32'd0);
        chk("midrst_count", 32'(press_count), 32'd0);
        exp_cnt = 8'd0;
        reset = 1'b0;
        p0 = pulses_seen;
        expect_pulse(cyc + 1 + D + 2);
        step(D + 4);
        chk("midrst_relevel", 32'(btn_level), 32'd1);
        chk("midrst_pulses", pulses_seen - p0, 32'd1);
        btn_raw = 1'b0;
        step(D + 4);

        // Long hold: 40 cycles past acceptance.
        p0 = pulses_seen;
        btn_raw = 1'b1;
        k = cyc + 1;
        a = k + D + 2;
        expect_pulse(a);
`ifdef STEP_PULSE_AUTO_REPEAT_EN
        for (int i = 20; i <= 40; i += 5) expect_pulse(a + i);
`endif
        step(D + 3 + 40);
        btn_raw = 1'b0;
        step(D + 4);
`ifdef STEP_PULSE_AUTO_REPEAT_EN
        chk("hold_pulses", pulses_seen - p0, 32'd6);
`else
        chk("hold_pulses", pulses_seen - p0, 32'd1);
`endif
        chk("hold_pending", 32'(exp_q.size()), 32'd0);

        // Wrap: 256 presses from a fresh reset return press_count to 0.
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        exp_cnt = 8'd0;
        chk("prewrap_count", 32'(press_count), 32'd0);
        p0 = pulses_seen;
        repeat (256) press_once();
        chk("wrap_count", 32'(press_count), 32'd0);
        chk("wrap_pulses", pulses_seen - p0, 32'd256);
        chk("final_pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
